rot_arb: RTL and testbench
==========================

# rot_arb

Round-robin scheduler sharing one `rot` barrel-rotator datapath among N_REQ requesters. Each requester presents an operand and rotate amount over a valid/ready handshake. The block arbitrates and registers the winner in front of the rotator. It registers the rotator output and returns the result, tagged with the requester id, on a single backpressured response channel.

## Interface
- `N`, 4096: operand width; must be a power of two.
- `log2_N`, 12: rotate-amount width.
- `N_REQ`, 4: number of requesters, ≥1.
- `ID_W`, 2: response id width, equal to clog2(max(N_REQ,2)).

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_ready`  out  N_REQ: per-requester accept; at most one bit high.
- `req_bits`  in  N_REQ*N: flat operands; requester r occupies slice [r*N +: N]; ascending [0:N-1] bit order inside a slice (bit 0 = MSB).
- `req_k`  in  N_REQ*log2_N: flat rotate amounts; k[0] = MSB.
- `req_dir`  in  N_REQ: 1 = rotate left. Present only with ROT_ARB_DIR_EN.
- `resp_valid`  out  1: result valid.
- `resp_ready`  in  1: consumer accept.
- `resp_bits`  out  N: rotated result, [0:N-1].
- `resp_id`  out  ID_W: index of the requester that produced the result.
- `busy`  out  1: stage A or stage B holds data.

## Operation
- Rotate semantics are right rotation by k: resp_bits[i] = operand[(i − k) mod N], with indices in the [0:N-1] order. k = 0 passes the operand through.
- Pipeline stages:
  - Stage A register: operand, effective k, id.
  - `rot` combinational datapath.
  - Stage B register: result, id.
- Stage ready signals:
  - b_ready = !b_valid || resp_ready.
  - a_ready = !a_valid || b_ready.
- Arbitration:
  - Round-robin over the requesters with req_valid high.
  - Search starts at last_grant+1 mod N_REQ.
  - The grant is issued only when a_ready is high.
  - req_ready[r] = grant[r] && a_ready; it is combinational from req_valid.
  - last_grant updates only on an accepted transfer (valid && ready).
- Requester rules:
  - A requester holds valid and data stable until ready.
  - Dropping valid before acceptance is illegal, and the bench flags it.
- Work-conserving: a single active requester is accepted every cycle that a_ready is high.
- Starvation bound: any valid requester is accepted within N_REQ accepted transfers.
- Backpressure:
  - While resp_valid && !resp_ready, resp_bits and resp_id hold stable.
  - Stage A holds when B cannot drain.
  - req_ready falls to 0 once both stages are full.
- No reordering: results leave in acceptance order.
- Reset values:
  - resp_valid = 0, resp_bits = 0, resp_id = 0, busy = 0.
  - Internal a_valid = 0, b_valid = 0, last_grant = N_REQ−1, so requester 0 has first priority.
  - req_ready = 0 while rst_n is low.
- Reset mid-operation discards both in-flight entries. No response is issued for them.

## Timing
- Accept at edge E0 loads stage A. Stage B loads at E1, so resp_valid rises after E1. Latency is 2 cycles.
- Throughput is 1 result per cycle with resp_ready held high.
- Simultaneous events:
  - B drains and A refills in the same cycle.
  - A transfers to B and a new accept lands in A on the same edge.
- Recovery from a full stall: when resp_ready returns high, req_ready is high in that same cycle.

## Configuration
- `ROT_ARB_DIR_EN` defined:
  - The `req_dir` port exists and is captured into stage A.
  - Effective k = dir ? (N − k) mod N : k, computed at capture in log2_N-bit wrap arithmetic.
  - Left rotation by 0 yields 0.
- `ROT_ARB_DIR_EN` undefined: the port is absent and all requests rotate right.

## Structure
- Package `rot_arb_pkg` holds:
  - the default N / log2_N / N_REQ constants;
  - the id-width function;
  - the stage-A entry struct typedef (operand, k, id, plus dir when enabled).
- Sub-module `rr_arbiter`: parameter N_REQ; inputs req, enable, accept; outputs one-hot grant and encoded grant id; owns the last_grant pointer.
- `rot_arb` instantiates `rr_arbiter` and one `rot`, and holds both pipeline registers.

## Test plan
- N=16, log2_N=4; requester 0 sends bits=0x8001, k=1 → resp_bits=0xC000, resp_id=0, two cycles after accept.
- With ROT_ARB_DIR_EN: bits=0x8001, k=1, dir=1 → 0x0003. Same operand with k=0, dir=1 → 0x8001.
- All 4 requesters valid continuously with resp_ready=1:
  - accept order 0,1,2,3,0,…, one per cycle;
  - resp_id follows the same order, delayed by 2 cycles.
- resp_ready held 0 for 5 cycles with requests pending:
  - exactly 2 accepts, then req_ready=0;
  - resp_bits/resp_id stable throughout;
  - on release, no result is lost or duplicated.
- Only requester 2 valid → accepted every cycle. When requester 1 also raises valid, grants alternate 1,2.
- rst_n pulsed low with both stages full:
  - resp_valid drops immediately and asynchronously;
  - after release, the first grant goes to requester 0;
  - no stale result appears.

Source files
------------

// File: rtl/rot_arb_pkg.sv
// Shared constants, id-width helper and stage-A entry layout for rot_arb.
// Optional feature macro: ROT_ARB_DIR_EN (adds a per-request direction bit).
package rot_arb_pkg;

  localparam int N_DEF      = 4096;
  localparam int LOG2_N_DEF = 12;
  localparam int N_REQ_DEF  = 4;

  // Response id width; a single requester still gets a 1-bit id.
  function automatic int id_width(input int n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

  localparam int ID_W_DEF = id_width(N_REQ_DEF);

  // Stage-A entry at the default geometry. The top module declares the same
  // shape locally so it can follow its own N / log2_N / ID_W parameters.
  typedef struct packed {
    logic [0:N_DEF-1]      bits;
    logic [0:LOG2_N_DEF-1] k;
    logic [ID_W_DEF-1:0]   id;
`ifdef ROT_ARB_DIR_EN
    logic                  dir;
`endif
  } stage_a_t;

endpackage

// File: rtl/rot_arb_if.sv
// Request/response bundle for rot_arb: per-requester valid/ready with flat
// operand and rotate-amount buses, and one backpressured response channel.
// Optional feature macro: ROT_ARB_DIR_EN (adds req_dir).
interface rot_arb_if #(
  parameter int N      = 4096,
  parameter int log2_N = 12,
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [0:N_REQ*N-1]        req_bits;
  logic [0:N_REQ*log2_N-1]   req_k;
`ifdef ROT_ARB_DIR_EN
  logic [N_REQ-1:0]          req_dir;
`endif
  logic                      resp_valid;
  logic                      resp_ready;
  logic [0:N-1]              resp_bits;
  logic [ID_W-1:0]           resp_id;

  // Requesters and response consumer.
  modport master (
    output req_valid, req_bits, req_k,
`ifdef ROT_ARB_DIR_EN
    output req_dir,
`endif
    output resp_ready,
    input  req_ready, resp_valid, resp_bits, resp_id
  );

  // The arbitrated rotator.
  modport slave (
    input  req_valid, req_bits, req_k,
`ifdef ROT_ARB_DIR_EN
    input  req_dir,
`endif
    input  resp_ready,
    output req_ready, resp_valid, resp_bits, resp_id
  );
endinterface

// File: rtl/rot_arb_rot.sv
// Combinational barrel rotator: right rotation by k in [0:N-1] bit order,
// i.e. dout[i] = din[(i - k) mod N]. N must equal 2**log2_N.
module rot
  import rot_arb_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int log2_N = LOG2_N_DEF
) (
  input  logic [0:N-1]      din,
  input  logic [0:log2_N-1] k,
  output logic [0:N-1]      dout
);

  logic [0:N-1] stage [0:log2_N];

  assign stage[0] = din;

  // k[0] is the MSB, so stage gi rotates by 2**(log2_N-1-gi) when its bit is set.
  for (genvar gi = 0; gi < log2_N; gi++) begin : g_stage
    localparam int SH = 1 << (log2_N - 1 - gi);
    assign stage[gi+1] = k[gi] ? {stage[gi][N-SH +: SH], stage[gi][0 +: N-SH]}
                               : stage[gi];
  end

  assign dout = stage[log2_N];

endmodule

// File: rtl/rot_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last_grant+1, issued only
// while enable is high; the pointer advances only on an accepted transfer.
module rr_arbiter
  import rot_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  logic [ID_W-1:0] last_grant_reg;
  logic            found;

  // Pick the first requester after the last winner, wrapping around.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(last_grant_reg) + 1 + i) % N_REQ;
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  // Reset to the last requester so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= ID_W'(N_REQ - 1);
    end else if (accept) begin
      last_grant_reg <= grant_id;
    end
  end

endmodule

// File: rtl/rot_arb.sv
// Round-robin shared barrel rotator: arbitrate -> stage A -> rot -> stage B.
// Optional feature macro: ROT_ARB_DIR_EN (left rotation via per-request dir).
module rot_arb
  import rot_arb_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int log2_N = LOG2_N_DEF,
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ID_W   = id_width(N_REQ)
) (
  input  logic     clk,
  input  logic     rst_n,
  rot_arb_if.slave bus,
  output logic     busy
);

  typedef struct packed {
    logic [0:N-1]      bits;
    logic [0:log2_N-1] k;
    logic [ID_W-1:0]   id;
  } a_entry_t;

  logic              a_valid_reg;
  a_entry_t          a_reg;
  a_entry_t          a_next;
  logic              b_valid_reg;
  logic [0:N-1]      b_bits_reg;
  logic [ID_W-1:0]   b_id_reg;
  logic [0:N-1]      rot_out;
  logic [0:log2_N-1] k_raw;
  logic              a_ready;
  logic              b_ready;
  logic              arb_en;
  logic              accept;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;

  assign b_ready = !b_valid_reg || bus.resp_ready;
  assign a_ready = !a_valid_reg || b_ready;
  // Gating with rst_n keeps req_ready low for the whole reset, not just after it.
  assign arb_en  = a_ready && rst_n;
  assign accept  = |grant;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid),
    .enable   (arb_en),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.req_ready = grant;

  // Select the winner's operand and form the effective rotate amount.
  always_comb begin
    a_next = '0;
    k_raw  = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant[r]) begin
        a_next.bits = bus.req_bits[r*N +: N];
        k_raw       = bus.req_k[r*log2_N +: log2_N];
        a_next.id   = ID_W'(r);
      end
    end
`ifdef ROT_ARB_DIR_EN
    // Left by k equals right by (N - k) mod N; wrap arithmetic maps 0 to 0.
    a_next.k = (|(bus.req_dir & grant)) ? ({log2_N{1'b0}} - k_raw) : k_raw;
`else
    a_next.k = k_raw;
`endif
  end

  // Stage A: load on accept, hold while stage B cannot take the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_reg <= 1'b0;
      a_reg       <= '0;
    end else if (a_ready) begin
      a_valid_reg <= accept;
      if (accept) begin
        a_reg <= a_next;
      end
    end
  end

  rot #(
    .N      (N),
    .log2_N (log2_N)
  ) u_rot (
    .din  (a_reg.bits),
    .k    (a_reg.k),
    .dout (rot_out)
  );

  // Stage B: capture the rotated result; holds stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_reg <= 1'b0;
      b_bits_reg  <= '0;
      b_id_reg    <= '0;
    end else if (b_ready) begin
      b_valid_reg <= a_valid_reg;
      if (a_valid_reg) begin
        b_bits_reg <= rot_out;
        b_id_reg   <= a_reg.id;
      end
    end
  end

  assign bus.resp_valid = b_valid_reg;
  assign bus.resp_bits  = b_bits_reg;
  assign bus.resp_id    = b_id_reg;
  assign busy           = a_valid_reg || b_valid_reg;

endmodule

// File: tb/tb_rot_arb.sv
// Directed bench for rot_arb at N=16, log2_N=4, N_REQ=4 with a response
// scoreboard. Optional feature macro: ROT_ARB_DIR_EN (adds direction tests).
module tb_rot_arb;

  localparam int N  = 16;
  localparam int LN = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  rot_arb_if #(.N(N), .log2_N(LN), .N_REQ(NR), .ID_W(IW)) bus();

  rot_arb #(.N(N), .log2_N(LN), .N_REQ(NR), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Requester model: rem[r] requests left; data changes only after acceptance.
  int          rem [NR];
  int          seq [NR];
  logic [15:0] base_bits [NR];
  int          base_k [NR];
  bit          base_dir [NR];
  bit          pend [NR];

  logic [IW-1:0] q_id [$];
  logic [15:0]   q_bits [$];
  logic [NR-1:0] last_acc;
  logic [NR-1:0] last_rdy;
  logic [15:0]   hold_bits;
  logic [IW-1:0] hold_id;
  int            nacc;

  logic [3:0] exp_rr2 [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0010,
                              4'b0100, 4'b0010, 4'b0100, 4'b0010};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_rot(input logic [15:0] v, input int k, input bit left);
    logic [0:15] a;
    logic [0:15] o;
    a = v;
    for (int i = 0; i < 16; i++) begin
      o[i] = left ? a[(i + k) % 16] : a[(i - k + 16) % 16];
    end
    return o;
  endfunction

  function automatic logic [15:0] cur_bits(input int r);
    return base_bits[r] + 16'(seq[r] * 257);
  endfunction

  function automatic int cur_k(input int r);
    return (base_k[r] + seq[r]) % 16;
  endfunction

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      bus.req_valid[r]         = (rem[r] > 0);
      bus.req_bits[r*N +: N]   = cur_bits(r);
      bus.req_k[r*LN +: LN]    = 4'(cur_k(r));
`ifdef ROT_ARB_DIR_EN
      bus.req_dir[r]           = base_dir[r];
`endif
    end
  endtask

  // One clock: drive at negedge, sample handshakes just before posedge,
  // return at the following negedge.
  task automatic cycle();
    drive();
    #1;
    for (int r = 0; r < NR; r++) begin
      if (pend[r] && !bus.req_valid[r]) check("valid_held", 0, 1);
    end
    last_rdy = bus.req_ready;
    last_acc = bus.req_valid & bus.req_ready;
    for (int r = 0; r < NR; r++) begin
      if (last_acc[r]) begin
        q_id.push_back(IW'(r));
        q_bits.push_back(model_rot(cur_bits(r), cur_k(r), base_dir[r]));
        rem[r]--;
        seq[r]++;
      end
      pend[r] = bus.req_valid[r] && !last_acc[r];
    end
    if (bus.resp_valid && bus.resp_ready) begin
      $display("resp id=%0d bits=%04h", bus.resp_id, bus.resp_bits);
      if (q_id.size() == 0) begin
        check("resp_extra", 1, 0);
      end else begin
        check("resp_id", bus.resp_id, q_id.pop_front());
        check("resp_bits", bus.resp_bits, q_bits.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send1(input int r, input logic [15:0] b, input int k, input bit d);
    base_bits[r] = b;
    base_k[r]    = k;
    base_dir[r]  = d;
    seq[r]       = 0;
    rem[r]       = 1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.resp_ready = 1'b1;
    while ((q_id.size() != 0 || (rem[0] + rem[1] + rem[2] + rem[3]) != 0) && n < 60) begin
      cycle();
      n++;
    end
    check("drain_empty", q_id.size(), 0);
    check("drain_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NR; r++) begin
      rem[r] = 0; seq[r] = 0; pend[r] = 1'b0; base_dir[r] = 1'b0;
      base_bits[r] = 16'h0; base_k[r] = 0;
    end
    bus.req_valid  = '0;
    bus.req_bits   = '0;
    bus.req_k      = '0;
`ifdef ROT_ARB_DIR_EN
    bus.req_dir    = '0;
`endif
    bus.resp_ready = 1'b0;

    // Reset state, with requests asserted during reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_bits", bus.resp_bits, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_busy", busy, 0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Single request: 0x8001 right by 1 -> 0xC000, valid after the second edge.
    bus.resp_ready = 1'b1;
    send1(0, 16'h8001, 1, 1'b0);
    cycle();
    check("t1_accept", last_acc, 4'b0001);
    check("t1_not_yet", bus.resp_valid, 0);
    cycle();
    check("t1_valid", bus.resp_valid, 1);
    check("t1_bits", bus.resp_bits, 16'hC000);
    check("t1_id", bus.resp_id, 0);
    cycle();
    check("t1_idle", busy, 0);

`ifdef ROT_ARB_DIR_EN
    // Left by 1 -> 0x0003; left by 0 passes through.
    send1(0, 16'h8001, 1, 1'b1);
    cycle(); cycle();
    check("dir_left1", bus.resp_bits, 16'h0003);
    send1(0, 16'h8001, 0, 1'b1);
    cycle(); cycle();
    check("dir_left0", bus.resp_bits, 16'h8001);
    base_dir[0] = 1'b0;
    drain();
`endif

    // All four requesters continuously valid; last winner was 0, so 1,2,3,0,...
    base_bits[0] = 16'h1234; base_k[0] = 0;
    base_bits[1] = 16'hA5C3; base_k[1] = 3;
    base_bits[2] = 16'h0F0F; base_k[2] = 7;
    base_bits[3] = 16'h8001; base_k[3] = 15;
    for (int r = 0; r < NR; r++) begin
      seq[r] = 0; rem[r] = 2;
    end
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_accept", last_acc, 1 << ((1 + i) % 4));
      if (i >= 1) begin
        check("rr_resp_valid", bus.resp_valid, 1);
        check("rr_resp_id", bus.resp_id, i % 4);
      end
    end
    drain();

    // Backpressure: 5 stalled cycles admit exactly two requests.
    for (int r = 0; r < NR; r++) rem[r] = 2;
    bus.resp_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (last_acc != 0) nacc++;
      if (i == 1) begin
        check("bp_valid", bus.resp_valid, 1);
        hold_bits = bus.resp_bits;
        hold_id   = bus.resp_id;
      end
      if (i >= 2) begin
        check("bp_ready_low", last_rdy, 0);
        check("bp_bits_hold", bus.resp_bits, hold_bits);
        check("bp_id_hold", bus.resp_id, hold_id);
      end
    end
    check("bp_accepts", nacc, 2);
    bus.resp_ready = 1'b1;
    cycle();
    check("bp_recover", |last_rdy, 1);
    drain();

    // Lone requester 2 accepted every cycle; then 1 joins and they alternate.
    rem[2] = 7;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) rem[1] = 4;
      cycle();
      check("rr2_accept", last_acc, exp_rr2[i]);
    end
    drain();

    // Reset with both stages full: outputs clear at once, entries discarded.
    bus.resp_ready = 1'b0;
    for (int r = 0; r < NR; r++) rem[r] = 1;
    cycle(); cycle();
    check("full_busy", busy, 1);
    check("full_valid", bus.resp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_resp_valid", bus.resp_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_req_ready", bus.req_ready, 0);
    q_id.delete();
    q_bits.delete();
    for (int r = 0; r < NR; r++) begin
      rem[r] = 0; pend[r] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    for (int r = 0; r < NR; r++) rem[r] = 1;
    cycle();
    check("post_rst_grant", last_acc, 4'b0001);
    cycle();
    check("post_rst_id", bus.resp_id, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
